// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, 1-cycle imem requests, credit-managed buffer to decode
// Redirect flushes buffered and in-flight instructions and restarts fetch at the new PC.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] instr_pc_plus4
);

  localparam int                    PTR_W      = $clog2(FIFO_DEPTH);
  localparam int                    CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  kill_q, kill_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] mem_instr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_instr_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc_q    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc_d    [FIFO_DEPTH];

  logic             pop;
  logic             push;
  logic [CNT_W:0]   used_slots;

  // A slot is reserved for every in-flight response, so a push never finds the buffer full.
  assign used_slots  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
  assign instr_valid = (count_q != '0) & ~redirect;
  assign pop         = instr_valid & instr_ready;
  assign push        = inflight_q & ~kill_q & ~redirect;
  assign imem_req    = rst_n & ~redirect & (used_slots < (CNT_W + 1)'(FIFO_DEPTH));
  assign imem_addr   = fetch_pc_q & ALIGN_MASK;

  assign instr          = mem_instr_q[rd_ptr_q];
  assign instr_pc       = mem_pc_q[rd_ptr_q];
  assign instr_pc_plus4 = mem_pc_q[rd_ptr_q] + PC_STEP;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    inflight_d  = imem_req;
    kill_d      = redirect & inflight_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_instr_d = mem_instr_q;
    mem_pc_d    = mem_pc_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
        req_pc_d   = fetch_pc_q;
      end
      if (push) begin
        mem_instr_d[wr_ptr_q] = imem_rdata;
        mem_pc_d[wr_ptr_q]    = req_pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC & ALIGN_MASK;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      kill_q      <= kill_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_instr_q <= mem_instr_d;
      mem_pc_q    <= mem_pc_d;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(FIFO_DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CNT_W'(FIFO_DEPTH)) && !pop));
  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
// Memory model returns addr ^ 32'hA5A5_0000 one cycle after each request.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pc_plus4(instr_pc_plus4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ K) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge; outputs are sampled 1ns later.
  task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    check({tag, "_pc"}, instr_pc, pc);
    check({tag, "_instr"}, instr, pc ^ K);
  endtask

  initial begin
    int n;

    // Reset state
    #2;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);

    // Cycle 0 after release: request at RESET_PC
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    #1;
    check("c0_req", {31'b0, imem_req}, 32'd1);
    check("c0_addr", imem_addr, 32'h0);
    check("c0_valid", {31'b0, instr_valid}, 32'd0);
    cycle(1, 0, 0);
    check("c1_valid", {31'b0, instr_valid}, 32'd0);
    check("c1_addr", imem_addr, 32'h4);
    cycle(1, 0, 0);
    expect_head("c2", 32'h0);
    check("c2_plus4", instr_pc_plus4, 32'h4);
    cycle(1, 0, 0);
    expect_head("c3", 32'h4);
    cycle(1, 0, 0);
    expect_head("c4", 32'h8);
    cycle(1, 0, 0);
    expect_head("c5", 32'hC);

    // Backpressure: head held at 0x10, FIFO fills, requests stop
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0);
      check("bp_req", {31'b0, imem_req}, 32'd0);
      expect_head("bp", 32'h10);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0);
      expect_head("rel", 32'h10 + 32'(4 * i));
    end

    // Redirect with one buffered entry and a response in flight
    cycle(0, 1, 32'h0000_1002);
    check("rd1_valid", {31'b0, instr_valid}, 32'd0);
    check("rd1_req", {31'b0, imem_req}, 32'd0);
    cycle(1, 0, 0);
    check("rd1_next_req", {31'b0, imem_req}, 32'd1);
    check("rd1_next_addr", imem_addr, 32'h0000_1000);
    check("rd1_killed", {31'b0, instr_valid}, 32'd0);
    cycle(1, 0, 0);
    check("rd1_gap", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      expect_head("rd1_seq", 32'h1000 + 32'(4 * i));
    end

    // Redirect coinciding with ready=1 and a single buffered entry: no pop
    cycle(1, 1, 32'h0000_2000);
    check("rd2_valid", {31'b0, instr_valid}, 32'd0);
    cycle(0, 0, 0);
    check("rd2_addr", imem_addr, 32'h0000_2000);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    expect_head("rd2_first", 32'h2000);

    // Asynchronous reset mid-stream with the buffer full
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, instr_valid}, 32'd0);
    check("arst_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    #1;
    check("arst_rel_req", {31'b0, imem_req}, 32'd1);
    check("arst_rel_addr", imem_addr, 32'h0);
    check("arst_rel_valid", {31'b0, instr_valid}, 32'd0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    expect_head("arst_first", 32'h0);

    // PC wrap
    cycle(1, 1, 32'hFFFF_FFFC);
    check("wrap_rd_req", {31'b0, imem_req}, 32'd0);
    n = 0;
    do begin
      cycle(1, 0, 0);
      n++;
    end while (!instr_valid && n < 8);
    expect_head("wrap0", 32'hFFFF_FFFC);
    check("wrap0_plus4", instr_pc_plus4, 32'h0);
    cycle(1, 0, 0);
    expect_head("wrap1", 32'h0);
    check("wrap1_plus4", instr_pc_plus4, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
